morse_mode_ctrl: RTL and testbench
==================================

# morse_mode_ctrl

Mode controller that arbitrates the Morse encoder and decoder engines from the mode switch (switch 12). It synchronises and debounces the raw switch, drains the active engine before hand-over, and enforces a dead-band in which neither engine drives the shared LED/buzzer/display path. It sits between the board switch and the `encode`/`decoder` instances in the top-level converter and replaces their direct `turn_on` wiring.

## Interface
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive stable synchronised samples required to accept a switch change (20 ms @ 100 MHz).
- `DRAIN_TIMEOUT`, 100_000_000: maximum cycles spent waiting for the active engine to go idle.
- `GUARD_CYCLES`, 16: dead-band cycles with both engines disabled.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `mode_sw`  in  1  raw switch 12 (0 = decode, 1 = encode); asynchronous to `clk`.
- `enc_busy`  in  1  encoder has a symbol or character in flight.
- `dec_busy`  in  1  decoder has a symbol or character in flight.
- `enc_en`  out  1  encoder turn_on.
- `dec_en`  out  1  decoder turn_on.
- `enc_flush`  out  1  request for the encoder to finish or abort the current character.
- `dec_flush`  out  1  request for the decoder to finish or abort the current character.
- `out_sel`  out  1  shared output mux select (0 = decoder, 1 = encoder).
- `cur_mode`  out  1  committed mode.
- `mode_chg`  out  1  one-cycle pulse when a new mode is committed.
- `drain_to`  out  1  one-cycle pulse when a drain ended by timeout.

## Operation
- Reset values: `cur_mode`=0, `out_sel`=0, `dec_en`=1, `enc_en`=0, both flushes 0, `mode_chg`=0, `drain_to`=0, state RUN. Synchroniser flops and `sw_db` reset to 0. All counters reset to 0.
- `mode_sw` passes through a 2-flop synchroniser and then a debouncer. `sw_db` takes the synchronised value only after it differs from `sw_db` for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count at 0.
- Request condition: `req` = (`sw_db` != `cur_mode`).
- RUN: the engine selected by `cur_mode` has its enable at 1; the other has 0; both flushes are 0. When `req` = 1, go to DRAIN.
- DRAIN: hold the active engine's enable at 1 and assert its flush. The timeout counter starts at 0 on entry.
  - If `req` falls (switch returned), go back to RUN with the same engine; flush drops. There is no `mode_chg`.
  - Otherwise, if the active engine's busy is 0, go to GUARD.
  - Otherwise, if the counter reaches `DRAIN_TIMEOUT`-1, pulse `drain_to` and go to GUARD.
  - The busy exit has priority over the timeout in the same cycle.
- GUARD: both enables are 0 and both flushes are 0. Count `GUARD_CYCLES`. On the last cycle, toggle `cur_mode` and `out_sel`, pulse `mode_chg`, and go to RUN. `sw_db` changes during GUARD are ignored; they are re-evaluated in RUN.
- The busy input of the inactive engine is ignored in every state.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- Raw edge to `sw_db` change: 2 + `DEBOUNCE_CYCLES` cycles (clean edge).
- `req` to flush asserted: 1 cycle (registered state).
- Busy low to both enables at 0: 1 cycle.
- GUARD lasts exactly `GUARD_CYCLES` cycles with both enables at 0. The new engine's enable rises on the cycle after `mode_chg`.
- All outputs are registered. `mode_chg` and `drain_to` are high for exactly one cycle.
- Reset mid-DRAIN or mid-GUARD: return immediately to reset values (decoder active) with no `mode_chg`.

## Structure
- Package `morse_pkg` holds:
  - the state enum {RUN, DRAIN, GUARD};
  - `MODE_DEC`=1'b0 and `MODE_ENC`=1'b1;
  - the default timing constants.
- Sub-module `switch_debounce` contains the synchroniser and the stable-count filter, and is parameterised by `DEBOUNCE_CYCLES`. It is reused for other board switches.
- The FSM and the drain/guard counters are in `morse_mode_ctrl`. The top-level converter instantiates it and drives `turn_on` from `enc_en`/`dec_en`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DRAIN_TIMEOUT`=20, `GUARD_CYCLES`=3.
- Reset, then idle: `dec_en`=1, `enc_en`=0, `out_sel`=0, and no pulses for 50 cycles.
- Clean 0→1 switch with both busy at 0: DRAIN lasts 1 cycle, then GUARD for 3 cycles with both enables at 0. `mode_chg` pulses once, then `enc_en`=1, `out_sel`=1, `cur_mode`=1. Total from the raw edge to `enc_en` is about 2+4+1+1+3+1 cycles.
- Switch bouncing 0/1 every 2 cycles for 30 cycles, then settling at 0: `sw_db` never changes and the enables never change.
- `dec_busy` held high for 10 cycles after the switch to 1: `dec_flush`=1 for those cycles, and GUARD starts the cycle after `dec_busy` falls. There is no `drain_to`.
- `dec_busy` stuck at 1: `drain_to` pulses after 20 DRAIN cycles, then normal GUARD and hand-over to the encoder.
- Switch returns to 0 (debounced) during DRAIN: back to RUN with `dec_en`=1 and `dec_flush`=0. There is no `mode_chg`.
- Reset asserted during GUARD: `dec_en`=1 and `cur_mode`=0 immediately.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse encode/decode mode controller.
//   state_t         : mode controller FSM states
//   MODE_DEC/ENC    : committed-mode encoding (matches switch 12 polarity)
//   DEF_*           : default timing at 100 MHz
package morse_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_ENC = 1'b1;

    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;   // 20 ms
    localparam int DEF_DRAIN_TIMEOUT   = 100_000_000; // 1 s
    localparam int DEF_GUARD_CYCLES    = 16;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stable-count filter for a board switch.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   sw_raw   : raw switch, asynchronous to clk
//   sw_db    : debounced level; follows the synchronised switch once it has
//              differed from sw_db for DEBOUNCE_CYCLES consecutive cycles
module switch_debounce
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sw_db <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            // Any sample agreeing with sw_db is a bounce: restart the count.
            if (sync2 == sw_db) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                sw_db <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_mode_ctrl.sv
// Arbitrates the Morse encoder and decoder engines from switch 12. The active
// engine is drained before hand-over and a dead-band keeps both engines off
// the shared LED/buzzer/display path while the output mux switches.
//   clk, rst            : system clock, asynchronous active-high reset
//   mode_sw             : raw mode switch (0 = decode, 1 = encode)
//   enc_busy, dec_busy  : engine has a symbol/character in flight
//   enc_en, dec_en      : engine turn_on
//   enc_flush, dec_flush: finish/abort current character request
//   out_sel             : shared output mux select (0 = decoder, 1 = encoder)
//   cur_mode            : committed mode
//   mode_chg            : one-cycle pulse on commit of a new mode
//   drain_to            : one-cycle pulse when a drain ended by timeout
//
// state | meaning
// RUN   | committed engine enabled, watching for a debounced mode request
// DRAIN | active engine still enabled and flushed, waiting for it to go idle
// GUARD | both engines disabled for GUARD_CYCLES, then commit the new mode
module morse_mode_ctrl
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
    parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic mode_sw,
    input  logic enc_busy,
    input  logic dec_busy,
    output logic enc_en,
    output logic dec_en,
    output logic enc_flush,
    output logic dec_flush,
    output logic out_sel,
    output logic cur_mode,
    output logic mode_chg,
    output logic drain_to
);

    localparam int                 DRAIN_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam int                 GUARD_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    logic               sw_db;
    logic               req;
    logic               act_busy;
    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [GUARD_W-1:0] guard_cnt;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .sw_raw(mode_sw),
        .sw_db (sw_db)
    );

    assign req = (sw_db != cur_mode);

    // Only the committed engine's busy matters; the other one is off.
    assign act_busy = (cur_mode == MODE_ENC) ? enc_busy : dec_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cur_mode  <= MODE_DEC;
            out_sel   <= 1'b0;
            dec_en    <= 1'b1;
            enc_en    <= 1'b0;
            enc_flush <= 1'b0;
            dec_flush <= 1'b0;
            mode_chg  <= 1'b0;
            drain_to  <= 1'b0;
            drain_cnt <= '0;
            guard_cnt <= '0;
        end else begin
            mode_chg <= 1'b0;
            drain_to <= 1'b0;
            case (state)
                RUN: begin
                    // Enables are refreshed here so the new engine comes up
                    // one cycle after the commit, never in the same cycle.
                    enc_en    <= (cur_mode == MODE_ENC);
                    dec_en    <= (cur_mode == MODE_DEC);
                    enc_flush <= 1'b0;
                    dec_flush <= 1'b0;
                    if (req) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        enc_flush <= (cur_mode == MODE_ENC);
                        dec_flush <= (cur_mode == MODE_DEC);
                    end
                end
                DRAIN: begin
                    if (!req) begin
                        state     <= RUN;
                        enc_flush <= 1'b0;
                        dec_flush <= 1'b0;
                    end else if (!act_busy || (drain_cnt >= DRAIN_LAST)) begin
                        // Busy exit wins; drain_to only when still busy.
                        drain_to  <= act_busy;
                        state     <= GUARD;
                        guard_cnt <= '0;
                        enc_en    <= 1'b0;
                        dec_en    <= 1'b0;
                        enc_flush <= 1'b0;
                        dec_flush <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_cnt >= GUARD_LAST) begin
                        state    <= RUN;
                        cur_mode <= ~cur_mode;
                        out_sel  <= ~out_sel;
                        mode_chg <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_mode_ctrl.sv
module tb_morse_mode_ctrl;

    logic clk;
    logic rst;
    logic mode_sw;
    logic enc_busy;
    logic dec_busy;
    logic enc_en;
    logic dec_en;
    logic enc_flush;
    logic dec_flush;
    logic out_sel;
    logic cur_mode;
    logic mode_chg;
    logic drain_to;

    int n_cmp = 0;
    int n_err = 0;

    morse_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DRAIN_TIMEOUT  (20),
        .GUARD_CYCLES   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_sw  (mode_sw),
        .enc_busy (enc_busy),
        .dec_busy (dec_busy),
        .enc_en   (enc_en),
        .dec_en   (dec_en),
        .enc_flush(enc_flush),
        .dec_flush(dec_flush),
        .out_sel  (out_sel),
        .cur_mode (cur_mode),
        .mode_chg (mode_chg),
        .drain_to (drain_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n posedges; returns on the following negedge (sample point).
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Decoder-active idle state.
    task automatic chk_dec_idle(input string tag);
        chk({tag, ".dec_en"},    dec_en,    1'b1);
        chk({tag, ".enc_en"},    enc_en,    1'b0);
        chk({tag, ".dec_flush"}, dec_flush, 1'b0);
        chk({tag, ".mode_chg"},  mode_chg,  1'b0);
        chk({tag, ".drain_to"},  drain_to,  1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst      = 1'b1;
        mode_sw  = 1'b0;
        enc_busy = 1'b0;
        dec_busy = 1'b0;
        cyc(3);

        // Reset values
        chk("rst.dec_en",    dec_en,    1'b1);
        chk("rst.enc_en",    enc_en,    1'b0);
        chk("rst.out_sel",   out_sel,   1'b0);
        chk("rst.cur_mode",  cur_mode,  1'b0);
        chk("rst.enc_flush", enc_flush, 1'b0);
        chk("rst.dec_flush", dec_flush, 1'b0);
        chk("rst.mode_chg",  mode_chg,  1'b0);
        chk("rst.drain_to",  drain_to,  1'b0);
        rst = 1'b0;

        // Idle 50 cycles
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk_dec_idle("idle");
            chk("idle.out_sel", out_sel, 1'b0);
        end

        // Clean 0->1, both idle. Edge k = k-th posedge after the raw change.
        mode_sw = 1'b1;
        cyc(5);
        chk("clean.e5.dec_flush", dec_flush, 1'b0);
        cyc(1);
        chk("clean.e6.dec_flush", dec_flush, 1'b0);
        chk("clean.e6.dec_en",    dec_en,    1'b1);
        cyc(1);
        chk("clean.e7.dec_flush", dec_flush, 1'b1);
        chk("clean.e7.dec_en",    dec_en,    1'b1);
        chk("clean.e7.enc_en",    enc_en,    1'b0);
        for (int i = 8; i <= 10; i++) begin
            cyc(1);
            chk("clean.guard.dec_en",    dec_en,    1'b0);
            chk("clean.guard.enc_en",    enc_en,    1'b0);
            chk("clean.guard.dec_flush", dec_flush, 1'b0);
            chk("clean.guard.mode_chg",  mode_chg,  1'b0);
        end
        cyc(1);
        chk("clean.e11.mode_chg", mode_chg, 1'b1);
        chk("clean.e11.enc_en",   enc_en,   1'b0);
        chk("clean.e11.cur_mode", cur_mode, 1'b1);
        chk("clean.e11.out_sel",  out_sel,  1'b1);
        cyc(1);
        chk("clean.e12.mode_chg", mode_chg, 1'b0);
        chk("clean.e12.enc_en",   enc_en,   1'b1);
        chk("clean.e12.dec_en",   dec_en,   1'b0);
        chk("clean.e12.out_sel",  out_sel,  1'b1);

        // Bounce every 2 cycles for 30 cycles, settle at 0
        mode_sw = 1'b0;
        do_reset();
        chk("bounce.pre.cur_mode", cur_mode, 1'b0);
        for (int i = 0; i < 30; i++) begin
            mode_sw = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            cyc(1);
            chk_dec_idle("bounce");
            chk("bounce.sw_db", dut.u_debounce.sw_db, 1'b0);
        end
        mode_sw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk_dec_idle("bounce.settle");
            chk("bounce.settle.sw_db", dut.u_debounce.sw_db, 1'b0);
        end

        // dec_busy held 10 cycles into DRAIN; enc_busy high must be ignored
        mode_sw  = 1'b1;
        dec_busy = 1'b1;
        enc_busy = 1'b1;
        cyc(7);
        chk("busy.e7.dec_flush", dec_flush, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("busy.hold.dec_flush", dec_flush, 1'b1);
            chk("busy.hold.dec_en",    dec_en,    1'b1);
            chk("busy.hold.enc_en",    enc_en,    1'b0);
            chk("busy.hold.drain_to",  drain_to,  1'b0);
        end
        dec_busy = 1'b0;
        cyc(1);
        chk("busy.e18.dec_en",    dec_en,    1'b0);
        chk("busy.e18.enc_en",    enc_en,    1'b0);
        chk("busy.e18.dec_flush", dec_flush, 1'b0);
        chk("busy.e18.drain_to",  drain_to,  1'b0);
        cyc(2);
        chk("busy.e20.mode_chg", mode_chg, 1'b0);
        cyc(1);
        chk("busy.e21.mode_chg", mode_chg, 1'b1);
        chk("busy.e21.drain_to", drain_to, 1'b0);
        cyc(1);
        chk("busy.e22.enc_en", enc_en, 1'b1);
        enc_busy = 1'b0;

        // dec_busy stuck: timeout after 20 DRAIN cycles
        mode_sw = 1'b0;
        do_reset();
        mode_sw  = 1'b1;
        dec_busy = 1'b1;
        cyc(26);
        chk("to.e26.drain_to",  drain_to,  1'b0);
        chk("to.e26.dec_flush", dec_flush, 1'b1);
        chk("to.e26.dec_en",    dec_en,    1'b1);
        cyc(1);
        chk("to.e27.drain_to",  drain_to,  1'b1);
        chk("to.e27.dec_en",    dec_en,    1'b0);
        chk("to.e27.dec_flush", dec_flush, 1'b0);
        cyc(1);
        chk("to.e28.drain_to", drain_to, 1'b0);
        chk("to.e28.enc_en",   enc_en,   1'b0);
        cyc(2);
        chk("to.e30.mode_chg", mode_chg, 1'b1);
        chk("to.e30.cur_mode", cur_mode, 1'b1);
        cyc(1);
        chk("to.e31.enc_en", enc_en, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("to.after.dec_en",    dec_en,    1'b0);
            chk("to.after.enc_flush", enc_flush, 1'b0);
            chk("to.after.drain_to",  drain_to,  1'b0);
        end
        dec_busy = 1'b0;

        // Switch returns to 0 during DRAIN
        mode_sw = 1'b0;
        do_reset();
        mode_sw  = 1'b1;
        dec_busy = 1'b1;
        cyc(7);
        chk("abort.e7.dec_flush", dec_flush, 1'b1);
        mode_sw = 1'b0;
        cyc(6);
        chk("abort.e13.dec_flush", dec_flush, 1'b1);
        cyc(1);
        chk("abort.e14.dec_flush", dec_flush, 1'b0);
        chk("abort.e14.dec_en",    dec_en,    1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk_dec_idle("abort.run");
            chk("abort.run.cur_mode", cur_mode, 1'b0);
        end
        dec_busy = 1'b0;

        // Reset during GUARD
        mode_sw = 1'b1;
        cyc(9);
        chk("grst.e9.dec_en", dec_en, 1'b0);
        rst = 1'b1;
        #1;
        chk("grst.dec_en",   dec_en,   1'b1);
        chk("grst.enc_en",   enc_en,   1'b0);
        chk("grst.cur_mode", cur_mode, 1'b0);
        chk("grst.out_sel",  out_sel,  1'b0);
        mode_sw = 1'b0;
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk_dec_idle("grst.after");
            chk("grst.after.cur_mode", cur_mode, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
